// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, sizes and GF(2^8) helpers
// Purpose: byte/state types, FSM encoding and the xtime/gmul3 helpers used
//          by the byte-serial ShiftRows+MixColumns stage.
// Ports:   none (package).
package aes_pkg;

   localparam int AES_NB     = 4;
   localparam int AES_NBYTES = 16;

   typedef logic [7:0] aes_byte_t;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } fsm_t;

   // Multiply by 2 in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
   function automatic aes_byte_t xtime(input aes_byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic aes_byte_t gmul3(input aes_byte_t x);
      return xtime(x) ^ x;
   endfunction

endpackage

// File: rtl/aes_shift_mix_serial_if.sv
// rtl/aes_shift_mix_serial_if.sv - byte stream in/out bundle for the ShiftRows+MixColumns stage
// Purpose: groups the input byte stream (idata/ivalid/iready) and the output
//          byte stream (odata/ovalid/oready).
// Modports: master = producer of idata / consumer of odata (upstream+downstream side),
//           slave  = the stage itself.
interface aes_shift_mix_serial_if;
   import aes_pkg::*;

   aes_byte_t idata;
   logic      ivalid;
   logic      iready;
   aes_byte_t odata;
   logic      ovalid;
   logic      oready;

   modport master (
      output idata, ivalid, oready,
      input  iready, odata, ovalid
   );

   modport slave (
      input  idata, ivalid, oready,
      output iready, odata, ovalid
   );

endinterface

// File: rtl/aes_mixcol_byte.sv
// rtl/aes_mixcol_byte.sv - one MixColumns output byte from a column
// Purpose: combinational; returns 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
//          (indices mod 4), or a_r when bypass_i is set.
// Ports:   a0_i..a3_i column bytes, row_i output row, bypass_i skip MixColumns,
//          byte_o result byte.
module aes_mixcol_byte
   import aes_pkg::*;
(
   input  aes_byte_t  a0_i,
   input  aes_byte_t  a1_i,
   input  aes_byte_t  a2_i,
   input  aes_byte_t  a3_i,
   input  logic [1:0] row_i,
   input  logic       bypass_i,
   output aes_byte_t  byte_o
);

   aes_byte_t col [4];
   aes_byte_t t0, t1, t2, t3;

   always_comb begin
      col[0] = a0_i;
      col[1] = a1_i;
      col[2] = a2_i;
      col[3] = a3_i;
      // 2-bit additions wrap, giving the mod-4 rotation for free.
      t0 = col[row_i];
      t1 = col[row_i + 2'd1];
      t2 = col[row_i + 2'd2];
      t3 = col[row_i + 2'd3];
      byte_o = bypass_i ? t0 : (xtime(t0) ^ gmul3(t1) ^ t2 ^ t3);
   end

endmodule

// File: rtl/aes_shift_mix_serial.sv
// rtl/aes_shift_mix_serial.sv - byte-serial AES ShiftRows+MixColumns stage
// Purpose: collects one 16-byte column-major state, then emits the 16
//          ShiftRows+MixColumns bytes in the same order. Fill and drain do
//          not overlap.
// Ports:   clk, rst (sync, active-high); bus (slave modport): idata/ivalid/iready
//          input stream, odata/ovalid/oready output stream; final_rnd only when
//          AES_FINAL_ROUND_EN is defined (1 = ShiftRows only for this block).
// Params:  NBYTES must be 16; OREG=1 registers odata/ovalid, 0 drives odata
//          combinationally from the buffer.
// Config:  AES_FINAL_ROUND_EN adds the final_rnd bypass input.
module aes_shift_mix_serial
   import aes_pkg::*;
#(
   parameter int NBYTES = 16,
   parameter bit OREG   = 1'b1
)
(
   input  logic clk,
   input  logic rst,
`ifdef AES_FINAL_ROUND_EN
   input  logic final_rnd,
`endif
   aes_shift_mix_serial_if.slave bus
);

   if (NBYTES != AES_NB * AES_NB) begin : g_bad_nbytes
      $error("aes_shift_mix_serial: NBYTES must be 16");
   end

   aes_byte_t  mem_q [AES_NBYTES];
   fsm_t       state_q;
   logic [3:0] wr_idx_q;
   logic [3:0] rd_idx_q;
   logic       iready_q;
   logic       ovalid_q;
   aes_byte_t  odata_q;

   logic       in_xfer;
   logic       out_xfer;
   logic       ovalid;
   logic       bypass;
   logic [3:0] rd_sel;
   logic [1:0] col_sel;
   logic [1:0] row_sel;
   aes_byte_t  mix_byte;

   assign in_xfer  = bus.ivalid && iready_q;
   assign ovalid   = OREG ? ovalid_q : (state_q == DRAIN);
   assign out_xfer = ovalid && bus.oready;

   // With the output register, a byte already sits in odata_q, so the
   // register is refilled from the byte after the one being transferred.
   assign rd_sel  = (OREG && ovalid_q) ? (rd_idx_q + 4'd1) : rd_idx_q;
   assign col_sel = rd_sel[3:2];
   assign row_sel = rd_sel[1:0];

   // ShiftRows as an index remap: tap j of column c comes from column (c+j)%4, row j.
   aes_mixcol_byte u_mix (
      .a0_i     (mem_q[{col_sel,         2'd0}]),
      .a1_i     (mem_q[{col_sel + 2'd1, 2'd1}]),
      .a2_i     (mem_q[{col_sel + 2'd2, 2'd2}]),
      .a3_i     (mem_q[{col_sel + 2'd3, 2'd3}]),
      .row_i    (row_sel),
      .bypass_i (bypass),
      .byte_o   (mix_byte)
   );

   assign bus.iready = iready_q;
   assign bus.ovalid = ovalid;
   assign bus.odata  = OREG ? odata_q : (ovalid ? mix_byte : 8'h00);

`ifdef AES_FINAL_ROUND_EN
   logic final_q;

   // Captured on the first byte of a block and held until the next block starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         final_q <= 1'b0;
      end else if (in_xfer && (wr_idx_q == 4'd0)) begin
         final_q <= final_rnd;
      end
   end

   assign bypass = final_q;
`else
   assign bypass = 1'b0;
`endif

   // State buffer is deliberately not reset; it is always fully rewritten before a drain.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         mem_q[wr_idx_q] <= bus.idata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         wr_idx_q <= 4'd0;
         rd_idx_q <= 4'd0;
         iready_q <= 1'b0;
         ovalid_q <= 1'b0;
         odata_q  <= 8'h00;
      end else begin
         case (state_q)
            FILL: begin
               iready_q <= 1'b1;
               if (in_xfer) begin
                  if (wr_idx_q == 4'd15) begin
                     wr_idx_q <= 4'd0;
                     iready_q <= 1'b0;
                     state_q  <= DRAIN;
                  end else begin
                     wr_idx_q <= wr_idx_q + 4'd1;
                  end
               end
            end
            DRAIN: begin
               iready_q <= 1'b0;
               if (out_xfer) begin
                  if (rd_idx_q == 4'd15) begin
                     rd_idx_q <= 4'd0;
                     iready_q <= 1'b1;
                     state_q  <= FILL;
                  end else begin
                     rd_idx_q <= rd_idx_q + 4'd1;
                  end
               end
               if (OREG) begin
                  if (out_xfer && (rd_idx_q == 4'd15)) begin
                     ovalid_q <= 1'b0;
                  end else if (!ovalid_q || out_xfer) begin
                     ovalid_q <= 1'b1;
                     odata_q  <= mix_byte;
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

endmodule
